// File: rtl/ysyx_24080006_pkg.sv
// Shared AXI channel structs, burst/FSM encodings and reset address for the core.
package ysyx_24080006_pkg;

    localparam logic [31:0] RST_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } axi_rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } axi_wr_state_e;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
    } axi_r_s2m_t;

    typedef struct packed {
        logic        awvalid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic awready;
        logic wready;
        logic bvalid;
    } axi_w_s2m_t;

endpackage

// File: rtl/ysyx_24080006_axi_addr_gen.sv
// Next beat address for an AXI burst; WRAP is handled as INCR.
module ysyx_24080006_axi_addr_gen
    import ysyx_24080006_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    always_comb begin
        next_addr = addr;
        if (burst != 2'(FIXED))
            next_addr = addr + (32'd1 << size);
    end

endmodule

// File: rtl/ysyx_24080006_axi_sram_slave.sv
// AXI4 slave over a word-wide SRAM model with independent read and write FSMs.
module ysyx_24080006_axi_sram_slave
    import ysyx_24080006_pkg::*;
#(
    parameter int          DEPTH  = 4096,
    parameter int          RD_LAT = 1,
    parameter logic [31:0] BASE   = RST_ADDR
) (
    input  logic       clock,
    input  logic       reset,
    input  axi_r_m2s_t r_m2s,
    output axi_r_s2m_t r_s2m,
    input  axi_w_m2s_t w_m2s,
    output axi_w_s2m_t w_s2m
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [7:0]  LAT_INIT = 8'(RD_LAT - 1);

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE) >> 2);
    endfunction

    logic [31:0] mem [DEPTH];

    // ---------------- read channel ----------------
    axi_rd_state_e rd_state, rd_next;
    logic [31:0]   rd_addr, rd_addr_nxt;
    logic [7:0]    rd_len, rd_beat, rd_lat;
    logic [2:0]    rd_size;
    logic [1:0]    rd_burst;

    ysyx_24080006_axi_addr_gen u_rd_agen (
        .addr      (rd_addr),
        .size      (rd_size),
        .burst     (rd_burst),
        .next_addr (rd_addr_nxt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_state <= R_IDLE;
        else       rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        r_s2m   = '0;
        case (rd_state)
            R_IDLE: begin
                r_s2m.arready = 1'b1;
                if (r_m2s.arvalid) rd_next = R_WAIT;
            end
            R_WAIT: begin
                if (rd_lat == 8'd0) rd_next = R_DATA;
            end
            R_DATA: begin
                r_s2m.rvalid = 1'b1;
                r_s2m.rdata  = mem[word_idx(rd_addr)];
                r_s2m.rlast  = (rd_beat == rd_len);
                if (r_m2s.rready && r_s2m.rlast) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_beat  <= '0;
            rd_lat   <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
        end else begin
            case (rd_state)
                R_IDLE: if (r_m2s.arvalid) begin
                    rd_addr  <= r_m2s.araddr;
                    rd_len   <= r_m2s.arlen;
                    rd_size  <= r_m2s.arsize;
                    rd_burst <= r_m2s.arburst;
                    rd_beat  <= '0;
                    rd_lat   <= LAT_INIT;
                end
                R_WAIT: if (rd_lat != 8'd0) rd_lat <= rd_lat - 8'd1;
                R_DATA: if (r_m2s.rready && rd_beat != rd_len) begin
                    rd_beat <= rd_beat + 8'd1;
                    rd_addr <= rd_addr_nxt;
                end
                default: ;
            endcase
        end
    end

    // ---------------- write channel ----------------
    axi_wr_state_e wr_state, wr_next;
    logic [31:0]   wr_addr, wr_addr_nxt;
    logic [2:0]    wr_size;
    logic [1:0]    wr_burst;
    logic          wr_fire;

    // The burst is terminated by wlast alone, so awlen carries no information here.
    logic unused_awlen;
    assign unused_awlen = ^w_m2s.awlen;

    ysyx_24080006_axi_addr_gen u_wr_agen (
        .addr      (wr_addr),
        .size      (wr_size),
        .burst     (wr_burst),
        .next_addr (wr_addr_nxt)
    );

    assign wr_fire = (wr_state == W_DATA) && w_m2s.wvalid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) wr_state <= W_IDLE;
        else       wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        w_s2m   = '0;
        case (wr_state)
            W_IDLE: begin
                w_s2m.awready = 1'b1;
                if (w_m2s.awvalid) wr_next = W_DATA;
            end
            W_DATA: begin
                w_s2m.wready = 1'b1;
                if (w_m2s.wvalid && w_m2s.wlast) wr_next = W_RESP;
            end
            W_RESP: begin
                w_s2m.bvalid = 1'b1;
                if (w_m2s.bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_addr  <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
        end else if (wr_state == W_IDLE && w_m2s.awvalid) begin
            wr_addr  <= w_m2s.awaddr;
            wr_size  <= w_m2s.awsize;
            wr_burst <= w_m2s.awburst;
        end else if (wr_fire) begin
            wr_addr  <= wr_addr_nxt;
        end
    end

    // Array is intentionally not reset; reads see a write from the following cycle.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            for (int b = 0; b < 4; b++)
                if (w_m2s.wstrb[b])
                    mem[word_idx(wr_addr)][b*8 +: 8] <= w_m2s.wdata[b*8 +: 8];
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_axi_sram_slave.sv
// Directed bench for the AXI SRAM slave: table of single reads plus burst/reset sequences.
module tb_ysyx_24080006_axi_sram_slave;
    import ysyx_24080006_pkg::*;

    localparam int          DEPTH  = 64;
    localparam int          RD_LAT = 2;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    axi_r_m2s_t r_m2s;
    axi_r_s2m_t r_s2m;
    axi_w_m2s_t w_m2s;
    axi_w_s2m_t w_s2m;

    always #5 clock = ~clock;

    ysyx_24080006_axi_sram_slave #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .BASE(BASE)) dut (
        .clock (clock),
        .reset (reset),
        .r_m2s (r_m2s),
        .r_s2m (r_s2m),
        .w_m2s (w_m2s),
        .w_s2m (w_s2m)
    );

    int checks = 0;
    int errors = 0;

    typedef logic [31:0] word_arr_t [16];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
        string       nm;
    } rd_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic word_arr_t mk(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        word_arr_t r;
        r = '{default: 32'h0};
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input word_arr_t exp, input bit toggle,
                            input string nm);
        int cyc, beat, guard;
        bit hold;
        @(negedge clock);
        chk({nm, ".arready"}, 32'(r_s2m.arready), 32'd1);
        r_m2s.arvalid = 1'b1;
        r_m2s.araddr  = addr;
        r_m2s.arlen   = len;
        r_m2s.arsize  = size;
        r_m2s.arburst = burst;
        @(negedge clock);
        r_m2s.arvalid = 1'b0;
        cyc = 0;
        while (!r_s2m.rvalid && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        chk({nm, ".latency"}, 32'(cyc), 32'(RD_LAT));
        beat = 0; hold = 1'b0; guard = 0;
        while (beat <= int'(len) && guard < 100) begin
            chk($sformatf("%s.rvalid[%0d]", nm, beat), 32'(r_s2m.rvalid), 32'd1);
            chk($sformatf("%s.rdata[%0d]", nm, beat), r_s2m.rdata, exp[beat]);
            chk($sformatf("%s.rlast[%0d]", nm, beat), 32'(r_s2m.rlast), 32'(beat == int'(len)));
            chk($sformatf("%s.arready_busy[%0d]", nm, beat), 32'(r_s2m.arready), 32'd0);
            r_m2s.rready = !(toggle && hold);
            hold = ~hold;
            @(negedge clock);
            if (r_m2s.rready) beat++;
            guard++;
        end
        if (guard >= 100) chk({nm, ".timeout"}, 32'd0, 32'd1);
        r_m2s.rready = 1'b0;
        chk({nm, ".rvalid_end"}, 32'(r_s2m.rvalid), 32'd0);
        chk({nm, ".rdata_idle"}, r_s2m.rdata, 32'd0);
        chk({nm, ".arready_end"}, 32'(r_s2m.arready), 32'd1);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input word_arr_t d, input int n,
                             input logic [3:0] strb, input int bdelay, input string nm);
        @(negedge clock);
        chk({nm, ".awready"}, 32'(w_s2m.awready), 32'd1);
        w_m2s.awvalid = 1'b1;
        w_m2s.awaddr  = addr;
        w_m2s.awlen   = len;
        w_m2s.awsize  = size;
        w_m2s.awburst = burst;
        @(negedge clock);
        w_m2s.awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.wready[%0d]", nm, i), 32'(w_s2m.wready), 32'd1);
            chk($sformatf("%s.awready_busy[%0d]", nm, i), 32'(w_s2m.awready), 32'd0);
            w_m2s.wvalid = 1'b1;
            w_m2s.wdata  = d[i];
            w_m2s.wstrb  = strb;
            w_m2s.wlast  = (i == n - 1);
            @(negedge clock);
        end
        w_m2s.wvalid = 1'b0;
        w_m2s.wlast  = 1'b0;
        chk({nm, ".bvalid"}, 32'(w_s2m.bvalid), 32'd1);
        chk({nm, ".wready_resp"}, 32'(w_s2m.wready), 32'd0);
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clock);
            chk($sformatf("%s.bvalid_hold[%0d]", nm, i), 32'(w_s2m.bvalid), 32'd1);
        end
        w_m2s.bready = 1'b1;
        @(negedge clock);
        w_m2s.bready = 1'b0;
        chk({nm, ".bvalid_end"}, 32'(w_s2m.bvalid), 32'd0);
        chk({nm, ".awready_end"}, 32'(w_s2m.awready), 32'd1);
    endtask

    rd_vec_t tbl [8];

    initial begin
        int cyc;
        r_m2s = '0;
        w_m2s = '0;

        tbl[0] = '{BASE,                     32'hDEADBEEF, "rd_word0"};
        tbl[1] = '{BASE + 32'd4,             32'h0000_0000, "rd_word1"};
        tbl[2] = '{BASE + 32'd8,             32'h0000_0001, "rd_word2"};
        tbl[3] = '{BASE + 32'd20,            32'h0000_0004, "rd_word5"};
        tbl[4] = '{BASE - 32'd4,             32'hCAFEF00D, "rd_top_word"};
        tbl[5] = '{BASE + 32'(DEPTH*4) + 32'd8, 32'h0000_0001, "rd_wrap_depth"};
        tbl[6] = '{BASE + 32'd24,            32'h0000_0066, "rd_overrun0"};
        tbl[7] = '{BASE + 32'd28,            32'h0000_0077, "rd_overrun1"};

        @(negedge clock);
        chk("rst.arready", 32'(r_s2m.arready), 32'd1);
        chk("rst.awready", 32'(w_s2m.awready), 32'd1);
        chk("rst.wready",  32'(w_s2m.wready),  32'd0);
        chk("rst.bvalid",  32'(w_s2m.bvalid),  32'd0);
        chk("rst.rvalid",  32'(r_s2m.rvalid),  32'd0);
        chk("rst.rlast",   32'(r_s2m.rlast),   32'd0);
        chk("rst.rdata",   r_s2m.rdata,        32'd0);
        @(negedge clock);
        reset = 1'b0;

        axi_write(BASE, 8'd7, 3'd2, 2'(INCR),
                  mk(32'hDEADBEEF, 0, 1, 2, 3, 4, 5, 6), 8, 4'hF, 0, "wr_preload");
        axi_write(BASE - 32'd4, 8'd0, 3'd2, 2'(INCR),
                  mk(32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0), 1, 4'hF, 0, "wr_top");
        // len 0 but two beats: second beat still lands, burst ends on wlast
        axi_write(BASE + 32'd24, 8'd0, 3'd2, 2'(INCR),
                  mk(32'h66, 32'h77, 0, 0, 0, 0, 0, 0), 2, 4'hF, 0, "wr_overrun");

        for (int i = 0; i < 8; i++)
            axi_read(tbl[i].addr, 8'd0, 3'd2, 2'(INCR),
                     mk(tbl[i].exp, 0, 0, 0, 0, 0, 0, 0), 1'b0, tbl[i].nm);

        axi_read(BASE + 32'd8, 8'd3, 3'd2, 2'(INCR), mk(1, 2, 3, 4, 0, 0, 0, 0), 1'b1, "rd_incr_toggle");
        axi_read(BASE + 32'd8, 8'd3, 3'd1, 2'(INCR), mk(1, 1, 2, 2, 0, 0, 0, 0), 1'b0, "rd_size1");
        axi_read(BASE + 32'd12, 8'd2, 3'd2, 2'(FIXED), mk(2, 2, 2, 0, 0, 0, 0, 0), 1'b0, "rd_fixed");
        axi_read(BASE - 32'd4, 8'd1, 3'd2, 2'(WRAP),
                 mk(32'hCAFEF00D, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0), 1'b0, "rd_wrap_top");

        axi_write(BASE + 32'd4, 8'd0, 3'd2, 2'(INCR),
                  mk(32'h11223344, 0, 0, 0, 0, 0, 0, 0), 1, 4'hF, 0, "wr_full");
        axi_write(BASE + 32'd4, 8'd0, 3'd2, 2'(INCR),
                  mk(32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 0), 1, 4'b0101, 3, "wr_strb");
        axi_read(BASE + 32'd4, 8'd0, 3'd2, 2'(INCR),
                 mk(32'h11BB33DD, 0, 0, 0, 0, 0, 0, 0), 1'b0, "rd_strb");

        axi_write(BASE, 8'd2, 3'd2, 2'(FIXED), mk(5, 6, 7, 0, 0, 0, 0, 0), 3, 4'hF, 1, "wr_fixed");
        axi_read(BASE, 8'd1, 3'd2, 2'(INCR), mk(7, 32'h11BB33DD, 0, 0, 0, 0, 0, 0), 1'b0, "rd_fixed_wr");

        fork
            axi_read(BASE + 32'd8, 8'd3, 3'd2, 2'(INCR), mk(1, 2, 3, 4, 0, 0, 0, 0), 1'b0, "cc_rd");
            axi_write(BASE + 32'd64, 8'd3, 3'd2, 2'(INCR),
                      mk(32'h10, 32'h11, 32'h12, 32'h13, 0, 0, 0, 0), 4, 4'hF, 0, "cc_wr");
        join
        axi_read(BASE + 32'd64, 8'd3, 3'd2, 2'(INCR),
                 mk(32'h10, 32'h11, 32'h12, 32'h13, 0, 0, 0, 0), 1'b0, "cc_readback");

        // reset in the middle of a read burst, after the first beat is taken
        @(negedge clock);
        r_m2s.arvalid = 1'b1;
        r_m2s.araddr  = BASE + 32'd8;
        r_m2s.arlen   = 8'd3;
        r_m2s.arsize  = 3'd2;
        r_m2s.arburst = 2'(INCR);
        @(negedge clock);
        r_m2s.arvalid = 1'b0;
        r_m2s.rready  = 1'b1;
        cyc = 0;
        while (!r_s2m.rvalid && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        chk("mid.beat0", r_s2m.rdata, 32'd1);
        @(negedge clock);
        chk("mid.beat1", r_s2m.rdata, 32'd2);
        #1 reset = 1'b1;
        #1;
        chk("mid.rvalid", 32'(r_s2m.rvalid), 32'd0);
        chk("mid.arready", 32'(r_s2m.arready), 32'd1);
        chk("mid.rdata", r_s2m.rdata, 32'd0);
        r_m2s.rready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        axi_read(BASE, 8'd0, 3'd2, 2'(INCR), mk(7, 0, 0, 0, 0, 0, 0, 0), 1'b0, "rd_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
